iobus_cmd_master: RTL and testbench
===================================

// Module: iobus_cmd_master
//
// PURPOSE
//  Initiator end of the OTTER IOBUS: turns queued read/write commands into IOBUS cycles.
//  Drives iobus_addr/iobus_out/iobus_wr into the board-side I/O responder and samples iobus_in.
//  Used for bring-up and self-test, replacing or muxed with OTTER_MCU. Same clock domain as the responder.
//  Every command returns exactly one in-order response.
//
// PARAMETERS
//  FIFO_DEPTH  4  command queue entries; power of 2, >= 2
//  SETUP_CYC   1  cycles iobus_addr is stable before the access cycle; >= 1
//
// PORTS
//  clk          in   1   clock, same clock as the IOBUS responder
//  RST          in   1   asynchronous, active-high reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   queue can accept; equals !full
//  cmd_we       in   1   1 = write, 0 = read
//  cmd_addr     in   32  IOBUS address
//  cmd_wdata    in   32  write data; ignored for reads
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   consumer accepts response
//  rsp_rdata    out  32  sampled iobus_in for reads; 32'h0 for writes
//  rsp_we       out  1   echo of cmd_we for this response
//  iobus_addr   out  32  IOBUS address
//  iobus_out    out  32  IOBUS write data
//  iobus_wr     out  1   IOBUS write strobe
//  iobus_in     in   32  IOBUS read data; combinational from responder mux
//  busy         out  1   FSM not IDLE or queue not empty
//
// BEHAVIOUR
//  Reset (asynchronous): queue emptied; FSM -> IDLE.
//   All outputs 0 except cmd_ready = 1; includes iobus_wr, iobus_addr, rsp_valid.
//   Reset mid-transaction aborts it; no write strobe is issued after RST rises.
//  Enqueue: on a clock edge with cmd_valid & cmd_ready.
//   Push while full is impossible (cmd_ready = 0). Pop and push in the same cycle are both legal.
//   No bypass: a command always passes through the queue.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP.
//   IDLE: when queue not empty, pop the head into holding regs and go to SETUP.
//    iobus_addr, iobus_out, iobus_wr = 0.
//   SETUP: drive iobus_addr = held addr; iobus_out = held wdata (0 for reads); iobus_wr = 0.
//    Stay SETUP_CYC cycles using a down-counter, then go to ACCESS.
//   ACCESS: exactly 1 cycle. iobus_addr and iobus_out held; iobus_wr = held we.
//    Reads: capture iobus_in into rsp_rdata at the end of this cycle. Writes: rsp_rdata <= 0.
//    Next state is RESP.
//   RESP: rsp_valid = 1; iobus_* = 0. Hold rsp_rdata and rsp_we stable until rsp_ready.
//    On rsp_ready: if queue not empty, pop and go to SETUP (back-to-back); else go to IDLE.
//  iobus_addr, iobus_out and iobus_wr are registered (no glitches). iobus_wr is high for exactly 1 cycle per write.
//  Latency (SETUP_CYC = 1): command accepted at edge E0.
//   SETUP after E1; ACCESS after E2; the responder register captures the write at E3.
//   rsp_valid rises after E3. In general, rsp_valid follows the accept edge by SETUP_CYC + 2 edges.
//  Throughput: back-to-back commands with rsp_ready held at 1 take SETUP_CYC + 2 cycles each.
//  Queue pointers are log2(FIFO_DEPTH) + 1 bits and wrap modulo 2*FIFO_DEPTH.
//   full  = MSBs differ and the lower bits are equal.
//   empty = pointers equal.
//  busy = (state != IDLE) | !empty.
//
// STRUCTURE
//  iobus_pkg:
//   IOBUS port-address localparams: 1100_8000, 1100_8004, 1100_C000, 1100_C004, 1100_C008.
//   state enum {IDLE, SETUP, ACCESS, RESP}.
//   struct iobus_cmd_t {we, addr[31:0], wdata[31:0]}.
//  Sub-module iobus_cmd_fifo: synchronous FIFO of iobus_cmd_t, async reset; ports push, pop, full, empty, head.
//  Top level: FSM, SETUP counter, holding regs, output regs.
//
// TESTING
//  1 Reset: RST=1 mid-ACCESS of a write -> iobus_wr=0 at once; after release the queue is empty,
//    busy=0, and the LED reg is unchanged.
//  2 Single write: cmd {we=1, 1100_C000, 0000_A5A5} -> iobus_wr high 1 cycle with addr/data stable;
//    leds=16'hA5A5; rsp_valid 3 edges after accept; rsp_rdata=0.
//  3 Single read: switches=16'h1234; cmd {we=0, 1100_8000} -> rsp_rdata=32'h0000_1234, rsp_we=0;
//    iobus_wr never asserted.
//  4 Full: rsp_ready=0; push 5 cmds -> cmd_ready=0 after 4 are queued (1 in flight + 3 queued + 1);
//    release rsp_ready -> all 5 responses in order; no loss or duplication.
//  5 Back-to-back: 3 writes to 1100_C000/C004/C008 with rsp_ready=1 -> strobes 3 cycles apart;
//    leds/segs/an hold the written values.
//  6 SETUP_CYC=3 build: read latency is 5 edges; iobus_addr is stable 3 cycles before ACCESS.

Source files
------------

// File: rtl/iobus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iobus_pkg
// Description : Shared types and IOBUS port addresses for the command master
// Revision    : 1.0 - initial release
// ============================================================================
package iobus_pkg;

    // Board-side IOBUS port map
    localparam logic [31:0] c_ADDR_SWITCHES = 32'h1100_8000;
    localparam logic [31:0] c_ADDR_BUTTONS  = 32'h1100_8004;
    localparam logic [31:0] c_ADDR_LEDS     = 32'h1100_C000;
    localparam logic [31:0] c_ADDR_SEGS     = 32'h1100_C004;
    localparam logic [31:0] c_ADDR_ANODES   = 32'h1100_C008;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iobus_cmd_t;

endpackage
`default_nettype wire

// File: rtl/iobus_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iobus_cmd_fifo
// Description : Synchronous command queue; extra pointer MSB separates full
//               from empty when the index bits match.
// Revision    : 1.0 - initial release
// ============================================================================
module iobus_cmd_fifo
    import iobus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       push,
    input  iobus_cmd_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output iobus_cmd_t head
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    iobus_cmd_t    r_mem [FIFO_DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage needs no reset: the empty flag masks stale entries
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        end
    end

    // Pointer update; both may move in the same cycle
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign head  = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/iobus_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : iobus_cmd_master
// Description : IOBUS initiator; queued read/write commands become
//               SETUP/ACCESS bus cycles with one in-order response each.
// Revision    : 1.0 - initial release
// ============================================================================
module iobus_cmd_master
    import iobus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_we,
    output logic [31:0] iobus_addr,
    output logic [31:0] iobus_out,
    output logic        iobus_wr,
    input  logic [31:0] iobus_in,
    output logic        busy
);

    localparam int              c_CW       = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(SETUP_CYC - 1);

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_we;
    logic [31:0]     r_iobus_addr;
    logic [31:0]     r_iobus_out;
    logic            r_iobus_wr;
    logic            r_rsp_valid;
    logic            r_rsp_we;
    logic [31:0]     r_rsp_rdata;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    iobus_cmd_t      w_cmd_in;
    iobus_cmd_t      w_head;

    assign w_push   = cmd_valid & ~w_full;
    // Pop from IDLE, or straight from RESP on handshake for back-to-back cycles
    assign w_pop    = ~w_empty & ((r_state == IDLE) | ((r_state == RESP) & rsp_ready));
    assign w_cmd_in = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};

    iobus_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .RST       (RST),
        .push      (w_push),
        .push_data (w_cmd_in),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // Bus-cycle sequencer; all bus and response outputs are registered here
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_iobus_addr <= '0;
            r_iobus_out  <= '0;
            r_iobus_wr   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_we     <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_we         <= w_head.we;
                        r_iobus_addr <= w_head.addr;
                        r_iobus_out  <= w_head.we ? w_head.wdata : 32'h0;
                        r_cnt        <= c_CNT_LOAD;
                        r_state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_iobus_wr <= r_we;
                        r_state    <= ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    r_iobus_wr   <= 1'b0;
                    r_iobus_addr <= '0;
                    r_iobus_out  <= '0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_we     <= r_we;
                    r_rsp_rdata  <= r_we ? 32'h0 : iobus_in;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            r_we         <= w_head.we;
                            r_iobus_addr <= w_head.addr;
                            r_iobus_out  <= w_head.we ? w_head.wdata : 32'h0;
                            r_cnt        <= c_CNT_LOAD;
                            r_state      <= SETUP;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = ~w_full;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_we     = r_rsp_we;
    assign iobus_addr = r_iobus_addr;
    assign iobus_out  = r_iobus_out;
    assign iobus_wr   = r_iobus_wr;
    assign busy       = (r_state != IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_iobus_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_iobus_cmd_master
// Description : Directed bench for iobus_cmd_master with a small board-side
//               responder model (switches, LEDs, 7-seg, anodes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iobus_cmd_master;

    localparam logic [31:0] A_SW   = 32'h1100_8000;
    localparam logic [31:0] A_LEDS = 32'h1100_C000;
    localparam logic [31:0] A_SEGS = 32'h1100_C004;
    localparam logic [31:0] A_AN   = 32'h1100_C008;

    logic        clk = 1'b0;
    logic        RST = 1'b1;

    // DUT A (SETUP_CYC = 1)
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_we;
    logic [31:0] rsp_rdata, iobus_addr, iobus_out, iobus_in;
    logic        iobus_wr, busy;

    // DUT B (SETUP_CYC = 3)
    logic        cmd_valid_b = 1'b0, cmd_ready_b, cmd_we_b = 1'b0;
    logic [31:0] cmd_addr_b = '0, cmd_wdata_b = '0;
    logic        rsp_valid_b, rsp_ready_b = 1'b1, rsp_we_b;
    logic [31:0] rsp_rdata_b, iobus_addr_b, iobus_out_b, iobus_in_b;
    logic        iobus_wr_b, busy_b;

    // Responder state
    logic [15:0] switches = 16'h0;
    logic [15:0] leds = 16'h0;
    logic [7:0]  segs = 8'h0;
    logic [3:0]  an   = 4'h0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          wr_cyc [64];
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;
    int          b_run = 0, b_setup_seen = 0, b_strobes = 0;
    logic [31:0] b_prev_addr = '0;

    iobus_cmd_master #(.FIFO_DEPTH(4), .SETUP_CYC(1)) dut (
        .clk(clk), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_we(rsp_we),
        .iobus_addr(iobus_addr), .iobus_out(iobus_out), .iobus_wr(iobus_wr),
        .iobus_in(iobus_in), .busy(busy)
    );

    iobus_cmd_master #(.FIFO_DEPTH(4), .SETUP_CYC(3)) dut_b (
        .clk(clk), .RST(RST),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_we(cmd_we_b),
        .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_we(rsp_we_b),
        .iobus_addr(iobus_addr_b), .iobus_out(iobus_out_b), .iobus_wr(iobus_wr_b),
        .iobus_in(iobus_in_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp write strobes
    always @(posedge clk) cyc <= cyc + 1;

    // Responder read mux (combinational, like the board)
    assign iobus_in = (iobus_addr == A_SW)   ? {16'h0, switches} :
                      (iobus_addr == A_LEDS) ? {16'h0, leds} :
                      (iobus_addr == A_SEGS) ? {24'h0, segs} : 32'h0;
    assign iobus_in_b = (iobus_addr_b == A_SW) ? 32'h0000_CAFE : 32'h0;

    // Responder output registers (not cleared by RST)
    always @(posedge clk) begin
        if (iobus_wr) begin
            case (iobus_addr)
                A_LEDS:  leds <= iobus_out[15:0];
                A_SEGS:  segs <= iobus_out[7:0];
                A_AN:    an   <= iobus_out[3:0];
                default: ;
            endcase
        end
    end

    // Strobe monitor for DUT A
    always @(negedge clk) begin
        if (iobus_wr) begin
            wr_cyc[wr_count % 64] <= cyc;
            wr_count              <= wr_count + 1;
            last_wr_addr          <= iobus_addr;
            last_wr_data          <= iobus_out;
        end
    end

    // Address-stability monitor for DUT B: setup cycles seen before each strobe
    always @(negedge clk) begin
        if (iobus_wr_b) begin
            b_setup_seen <= b_run;
            b_strobes    <= b_strobes + 1;
        end else if (iobus_addr_b != 32'h0) begin
            b_run <= (iobus_addr_b == b_prev_addr) ? b_run + 1 : 1;
        end else begin
            b_run <= 0;
        end
        b_prev_addr <= iobus_addr_b;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic [31:0] exp_rdata;
        logic [15:0] exp_leds;
    } vec_t;

    vec_t vecs [6];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            check32("send_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic send_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        cmd_we_b = we; cmd_addr_b = addr; cmd_wdata_b = wdata; cmd_valid_b = 1'b1;
        n = 0;
        while (!cmd_ready_b && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready_b) begin
            check32("send_b_timeout", 32'd0, 32'd1);
            cmd_valid_b = 1'b0;
        end else begin
            @(posedge clk); #1;
            cmd_valid_b = 1'b0;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) check32("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp_b(output int lat);
        lat = 0;
        while (!rsp_valid_b && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid_b) check32("rsp_b_timeout", 32'd0, 32'd1);
    endtask

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat, wc0, n;
        logic [31:0] full_rdata [5];
        logic        full_we    [5];

        vecs[0] = '{1'b1, A_LEDS, 32'h0000_A5A5, 16'h0000, 32'h0000_0000, 16'hA5A5};
        vecs[1] = '{1'b0, A_SW,   32'h0000_0000, 16'h1234, 32'h0000_1234, 16'hA5A5};
        vecs[2] = '{1'b0, A_LEDS, 32'h0000_0000, 16'h1234, 32'h0000_A5A5, 16'hA5A5};
        vecs[3] = '{1'b1, A_LEDS, 32'hFFFF_0001, 16'h1234, 32'h0000_0000, 16'h0001};
        vecs[4] = '{1'b0, A_SW,   32'hDEAD_BEEF, 16'hFFFF, 32'h0000_FFFF, 16'h0001};
        vecs[5] = '{1'b1, A_SEGS, 32'h1234_565A, 16'hFFFF, 32'h0000_0000, 16'h0001};

        full_rdata[0] = 32'h0000_0000; full_we[0] = 1'b1;
        full_rdata[1] = 32'h0000_1111; full_we[1] = 1'b0;
        full_rdata[2] = 32'h0000_0000; full_we[2] = 1'b1;
        full_rdata[3] = 32'h0000_2222; full_we[3] = 1'b0;
        full_rdata[4] = 32'h0000_BEEF; full_we[4] = 1'b0;

        // ---- reset state ----
        @(posedge clk); #1;
        check32("rst_cmd_ready",  {31'h0, cmd_ready}, 32'd1);
        check32("rst_rsp_valid",  {31'h0, rsp_valid}, 32'd0);
        check32("rst_iobus_wr",   {31'h0, iobus_wr},  32'd0);
        check32("rst_iobus_addr", iobus_addr,         32'h0);
        check32("rst_iobus_out",  iobus_out,          32'h0);
        check32("rst_rsp_rdata",  rsp_rdata,          32'h0);
        check32("rst_busy",       {31'h0, busy},      32'd0);
        RST = 1'b0;
        @(posedge clk); #1;

        // ---- single commands from the vector table ----
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            switches = vecs[i].sw;
            wc0 = wr_count;
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            wait_rsp(lat);
            check32($sformatf("v%0d_latency", i), lat, 32'd3);
            check32($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
            check32($sformatf("v%0d_rsp_we", i), {31'h0, rsp_we}, {31'h0, vecs[i].we});
            check32($sformatf("v%0d_strobes", i), wr_count - wc0, vecs[i].we ? 32'd1 : 32'd0);
            if (vecs[i].we) begin
                check32($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].addr);
                check32($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].wdata);
            end
            check32($sformatf("v%0d_leds", i), {16'h0, leds}, {16'h0, vecs[i].exp_leds});
            @(posedge clk); #1;
        end
        check32("segs_after_table", {24'h0, segs}, 32'h0000_005A);

        // ---- reset in the middle of a write ACCESS ----
        wc0 = wr_count;
        send(1'b1, A_LEDS, 32'h0000_DEAD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check32("rst_mid_pre_strobe", {31'h0, iobus_wr}, 32'd1);
        RST = 1'b1;
        #1;
        check32("rst_mid_wr_low",   {31'h0, iobus_wr}, 32'd0);
        check32("rst_mid_addr_low", iobus_addr, 32'h0);
        @(posedge clk); #1;
        RST = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check32("rst_mid_busy",      {31'h0, busy}, 32'd0);
        check32("rst_mid_cmd_ready", {31'h0, cmd_ready}, 32'd1);
        check32("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check32("rst_mid_leds",      {16'h0, leds}, 32'h0000_0001);
        check32("rst_mid_strobes",   wr_count - wc0, 32'd0);

        // ---- queue full with responses stalled ----
        rsp_ready = 1'b0;
        switches  = 16'hBEEF;
        send(1'b1, A_LEDS, 32'h0000_1111);
        send(1'b0, A_LEDS, 32'h0);
        send(1'b1, A_LEDS, 32'h0000_2222);
        send(1'b0, A_LEDS, 32'h0);
        send(1'b0, A_SW,   32'h0);
        check32("full_cmd_ready", {31'h0, cmd_ready}, 32'd0);
        check32("full_busy",      {31'h0, busy}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        check32("full_cmd_ready_hold", {31'h0, cmd_ready}, 32'd0);
        check32("full_rsp_waiting",    {31'h0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(lat);
            check32($sformatf("full_r%0d_rdata", i), rsp_rdata, full_rdata[i]);
            check32($sformatf("full_r%0d_we", i), {31'h0, rsp_we}, {31'h0, full_we[i]});
            @(posedge clk); #1;
        end
        repeat (6) begin @(posedge clk); #1; end
        check32("full_no_extra_rsp", {31'h0, rsp_valid}, 32'd0);
        check32("full_drained_busy", {31'h0, busy}, 32'd0);
        check32("full_leds",         {16'h0, leds}, 32'h0000_2222);

        // ---- back-to-back writes ----
        wc0 = wr_count;
        send(1'b1, A_LEDS, 32'h00C0_FFEE);
        send(1'b1, A_SEGS, 32'h0000_003C);
        send(1'b1, A_AN,   32'h0000_000A);
        n = 0;
        while (busy && n < 60) begin @(posedge clk); #1; n++; end
        check32("b2b_idle",     {31'h0, busy}, 32'd0);
        check32("b2b_strobes",  wr_count - wc0, 32'd3);
        check32("b2b_gap01",    wr_cyc[(wc0 + 1) % 64] - wr_cyc[wc0 % 64], 32'd3);
        check32("b2b_gap12",    wr_cyc[(wc0 + 2) % 64] - wr_cyc[(wc0 + 1) % 64], 32'd3);
        check32("b2b_leds",     {16'h0, leds}, 32'h0000_FFEE);
        check32("b2b_segs",     {24'h0, segs}, 32'h0000_003C);
        check32("b2b_an",       {28'h0, an},   32'h0000_000A);

        // ---- SETUP_CYC = 3 instance ----
        send_b(1'b0, A_SW, 32'h0);
        wait_rsp_b(lat);
        check32("s3_read_latency", lat, 32'd5);
        check32("s3_read_rdata",   rsp_rdata_b, 32'h0000_CAFE);
        check32("s3_read_we",      {31'h0, rsp_we_b}, 32'd0);
        @(posedge clk); #1;
        send_b(1'b1, A_LEDS, 32'h0000_0077);
        wait_rsp_b(lat);
        check32("s3_write_latency", lat, 32'd5);
        check32("s3_addr_setup",    b_setup_seen, 32'd3);
        check32("s3_strobes",       b_strobes, 32'd1);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
